// File: rtl/ldlt_arbiter.sv
// Two-requester round-robin front end for a shared 6x6 LDLT engine.
// One job in flight: IDLE -> LAUNCH (start pulse) -> WAIT (capture or timeout) -> RESP (held until consumed).
module ldlt_arbiter #(
  parameter int MATRIX_BW      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_req_valid,
  output logic [1:0]                o_req_ready,
  input  logic [21*MATRIX_BW-1:0]   i_req0_mat,
  input  logic [21*MATRIX_BW-1:0]   i_req1_mat,
  output logic [1:0]                o_rsp_valid,
  input  logic [1:0]                i_rsp_ready,
  output logic [21*MATRIX_BW-1:0]   o_rsp_mat,
  output logic [1:0]                o_rsp_status,
  output logic                      o_ldlt_start,
  output logic [21*MATRIX_BW-1:0]   o_ldlt_mat,
  input  logic                      i_ldlt_done,
  input  logic                      i_ldlt_div_zero,
  input  logic [21*MATRIX_BW-1:0]   i_ldlt_mat,
  output logic                      o_busy,
  output logic                      o_timeout_err
);

  localparam int MW = 21 * MATRIX_BW;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            grant_id_q, grant_id_d;
  logic            last_grant_q, last_grant_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [MW-1:0]   ldlt_mat_q, ldlt_mat_d;
  logic [MW-1:0]   rsp_mat_q, rsp_mat_d;
  logic [1:0]      status_q, status_d;
  logic            timeout_err_q, timeout_err_d;
  logic            grant;
  logic            diag_zero;

  // Packed offsets of the six diagonal entries: 00,11,22,33,44,55.
  assign diag_zero = (i_ldlt_mat[ 0*MATRIX_BW +: MATRIX_BW] == '0) ||
                     (i_ldlt_mat[ 6*MATRIX_BW +: MATRIX_BW] == '0) ||
                     (i_ldlt_mat[11*MATRIX_BW +: MATRIX_BW] == '0) ||
                     (i_ldlt_mat[15*MATRIX_BW +: MATRIX_BW] == '0) ||
                     (i_ldlt_mat[18*MATRIX_BW +: MATRIX_BW] == '0) ||
                     (i_ldlt_mat[20*MATRIX_BW +: MATRIX_BW] == '0);

  always_comb begin
    grant = i_req_valid[1];
    if (i_req_valid == 2'b11) grant = ~last_grant_q;
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    ldlt_mat_d    = ldlt_mat_q;
    rsp_mat_d     = rsp_mat_q;
    status_d      = status_q;
    timeout_err_d = timeout_err_q;
    o_req_ready   = 2'b00;
    o_ldlt_start  = 1'b0;
    o_rsp_valid   = 2'b00;
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so every output reads 0 while reset is held.
        if ((i_req_valid != 2'b00) && !i_rst) begin
          o_req_ready = grant ? 2'b10 : 2'b01;
          ldlt_mat_d  = grant ? i_req1_mat : i_req0_mat;
          grant_id_d  = grant;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        o_ldlt_start = 1'b1;
        timer_d      = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (i_ldlt_done) begin
          rsp_mat_d = i_ldlt_mat;
          status_d  = (i_ldlt_div_zero || diag_zero) ? 2'b01 : 2'b00;
          state_d   = RESP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_mat_d     = '0;
          status_d      = 2'b10;
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = grant_id_q ? 2'b10 : 2'b01;
        if (i_rsp_ready[grant_id_q]) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      grant_id_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      timer_q       <= '0;
      ldlt_mat_q    <= '0;
      rsp_mat_q     <= '0;
      status_q      <= 2'b00;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      ldlt_mat_q    <= ldlt_mat_d;
      rsp_mat_q     <= rsp_mat_d;
      status_q      <= status_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign o_busy        = (state_q != IDLE);
  assign o_ldlt_mat    = ldlt_mat_q;
  assign o_rsp_mat     = rsp_mat_q;
  assign o_rsp_status  = status_q;
  assign o_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ldlt_arbiter.sv
// Bench for ldlt_arbiter: engine stub, transaction-level reference model checked every cycle, directed scenarios.
module tb_ldlt_arbiter;
  localparam int BW = 16;
  localparam int MW = 21 * BW;
  localparam int TO = 255;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [1:0]    i_req_valid = 2'b00;
  logic [1:0]    o_req_ready;
  logic [MW-1:0] i_req0_mat = '0;
  logic [MW-1:0] i_req1_mat = '0;
  logic [1:0]    o_rsp_valid;
  logic [1:0]    i_rsp_ready = 2'b00;
  logic [MW-1:0] o_rsp_mat;
  logic [1:0]    o_rsp_status;
  logic          o_ldlt_start;
  logic [MW-1:0] o_ldlt_mat;
  logic          i_ldlt_done = 1'b0;
  logic          i_ldlt_div_zero = 1'b0;
  logic [MW-1:0] i_ldlt_mat = '0;
  logic          o_busy;
  logic          o_timeout_err;

  ldlt_arbiter #(.MATRIX_BW(BW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req0_mat(i_req0_mat), .i_req1_mat(i_req1_mat),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_mat(o_rsp_mat), .o_rsp_status(o_rsp_status),
    .o_ldlt_start(o_ldlt_start), .o_ldlt_mat(o_ldlt_mat),
    .i_ldlt_done(i_ldlt_done), .i_ldlt_div_zero(i_ldlt_div_zero), .i_ldlt_mat(i_ldlt_mat),
    .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [MW-1:0] mk(input int base, input int step);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < 21; i++) m[i*BW +: BW] = BW'(base + i * step);
    return m;
  endfunction

  // Column-major lower triangle: column c starts after sum_{j<c}(6-j) entries.
  function automatic int diag_pos(input int c);
    int s;
    s = 0;
    for (int j = 0; j < c; j++) s += 6 - j;
    return s;
  endfunction

  // ---------------- reference model (job-level bookkeeping) ----------------
  bit            m_busy, m_resp, m_grant, m_last, m_err;
  int            m_age;
  logic [MW-1:0] m_op, m_rsp;
  logic [1:0]    m_st;

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_grant = 0; m_last = 1; m_err = 0;
    m_age = 0; m_op = '0; m_rsp = '0; m_st = 2'b00;
  endtask

  function automatic bit m_pick(input logic [1:0] v);
    if (v == 2'b11) return !m_last;
    return v[1];
  endfunction

  task automatic model_step();
    bit z;
    if (!m_busy) begin
      if (i_req_valid != 2'b00) begin
        m_grant = m_pick(i_req_valid);
        m_op    = m_grant ? i_req1_mat : i_req0_mat;
        m_busy  = 1; m_resp = 0; m_age = 1;
      end
    end else if (m_resp) begin
      if (i_rsp_ready[m_grant]) begin
        m_last = m_grant; m_busy = 0; m_resp = 0;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (i_ldlt_done) begin
      z = 0;
      for (int c = 0; c < 6; c++) if (i_ldlt_mat[diag_pos(c)*BW +: BW] == '0) z = 1;
      m_rsp = i_ldlt_mat; m_st = (i_ldlt_div_zero || z) ? 2'b01 : 2'b00; m_resp = 1;
    end else if (m_age - 2 == TO - 1) begin
      m_rsp = '0; m_st = 2'b10; m_err = 1; m_resp = 1;
    end else begin
      m_age++;
    end
  endtask

  initial begin
    logic [1:0] e_rdy, e_rv;
    model_reset();
    forever begin
      @(negedge i_clk);
      if (i_rst) model_reset();
      e_rdy = (!m_busy && !i_rst && i_req_valid != 2'b00) ? (m_pick(i_req_valid) ? 2'b10 : 2'b01) : 2'b00;
      e_rv  = (m_busy && m_resp) ? (m_grant ? 2'b10 : 2'b01) : 2'b00;
      chk("m_req_ready", MW'(o_req_ready), MW'(e_rdy));
      chk("m_start", MW'(o_ldlt_start), MW'(m_busy && !m_resp && m_age == 1));
      chk("m_rsp_valid", MW'(o_rsp_valid), MW'(e_rv));
      chk("m_busy", MW'(o_busy), MW'(m_busy));
      chk("m_ldlt_mat", o_ldlt_mat, m_op);
      chk("m_rsp_mat", o_rsp_mat, m_rsp);
      chk("m_status", MW'(o_rsp_status), MW'(m_st));
      chk("m_timeout_err", MW'(o_timeout_err), MW'(m_err));
      @(posedge i_clk);
      if (i_rst) model_reset();
      else model_step();
    end
  end

  // ---------------- engine stub ----------------
  logic [MW-1:0] stub_res = '0;
  bit            stub_dz = 0;
  int            stub_delay = 0;
  int            start_cyc = 0, done_cyc = 0;
  int            late_req = 0, late_seen = 0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (late_req != late_seen) begin
        late_seen++;
        @(posedge i_clk); #2;
        i_ldlt_done = 1'b1; i_ldlt_mat = mk('h7777, 1);
        @(posedge i_clk); #2;
        i_ldlt_done = 1'b0;
      end else if (o_ldlt_start) begin
        start_cyc = cyc;
        if (stub_delay > 0) begin
          repeat (stub_delay) @(posedge i_clk);
          #2;
          i_ldlt_done = 1'b1; i_ldlt_div_zero = stub_dz; i_ldlt_mat = stub_res;
          done_cyc = cyc;
          @(posedge i_clk); #2;
          i_ldlt_done = 1'b0; i_ldlt_div_zero = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic bit cond(input int what);
    case (what)
      0: return o_req_ready != 2'b00;
      1: return o_ldlt_start;
      2: return o_rsp_valid != 2'b00;
      3: return !o_busy;
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int what, input int bound, output int at);
    at = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge i_clk);
      if (cond(what)) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL wait_event%0d: got no event within %0d cycles, expected one", what, bound);
    end
  endtask

  task automatic consume(input bit k);
    @(posedge i_clk); #2;
    i_rsp_ready = k ? 2'b10 : 2'b01;
    @(posedge i_clk); #2;
    i_rsp_ready = 2'b00;
  endtask

  task automatic run_job(input bit k, input logic [MW-1:0] mat, input logic [MW-1:0] res,
                         input bit dz, input int delay, input int bound, output int rv);
    int t;
    @(posedge i_clk); #2;
    stub_res = res; stub_dz = dz; stub_delay = delay;
    if (k) i_req1_mat = mat; else i_req0_mat = mat;
    i_req_valid = k ? 2'b10 : 2'b01;
    wait_for(0, 10, t);
    @(posedge i_clk); #2;
    i_req_valid = 2'b00;
    wait_for(2, bound, rv);
  endtask

  logic [MW-1:0] A, B0, B1, C, D, P, Z22, Z55;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, rv, rc, at;
    bit g;
    logic [MW-1:0] snap_mat;
    logic [1:0] snap_st;
    A = mk('h0100, 1); B0 = mk('h1000, 2); B1 = mk('h3000, 5);
    C = mk('h4000, 1); D = mk('h5000, 7); P = mk('h2001, 3);
    Z22 = P; Z22[diag_pos(2)*BW +: BW] = '0;
    Z55 = P; Z55[diag_pos(5)*BW +: BW] = '0;

    // Reset with both requesters already valid: outputs must all read 0.
    #1 i_rst = 1'b1;
    i_req0_mat = B0; i_req1_mat = B1; i_req_valid = 2'b11;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_outputs", MW'({o_req_ready, o_rsp_valid, o_rsp_status, o_ldlt_start, o_busy, o_timeout_err}), '0);
    chk("reset_mats", o_ldlt_mat | o_rsp_mat, '0);
    @(posedge i_clk); #2;
    i_rst = 1'b0; i_rsp_ready = 2'b11; stub_delay = 5;

    // Fairness: continuous ties alternate 0,1,0,1.
    for (int j = 0; j < 4; j++) begin
      wait_for(0, 40, t);
      g = o_req_ready[1];
      chk("fair_grant", MW'(g), MW'(j % 2));
      wait_for(1, 5, s);
      chk("fair_operand", o_ldlt_mat, g ? B1 : B0);
    end
    @(posedge i_clk); #2;
    i_req_valid = 2'b00;
    wait_for(3, 40, at);
    @(posedge i_clk); #2;
    i_rsp_ready = 2'b00;

    // Single job with the standard 148-cycle engine.
    i_req0_mat = A; stub_res = P; stub_dz = 0; stub_delay = 148; i_req_valid = 2'b01;
    wait_for(0, 10, t);
    chk("t1_ready", MW'(o_req_ready), MW'(2'b01));
    @(posedge i_clk); #2;
    i_req_valid = 2'b00;
    wait_for(1, 5, s);
    chk("t1_start_cycle", MW'(s), MW'(t + 1));
    wait_for(2, 400, rv);
    chk("t1_rsp_after_done", MW'(rv), MW'(done_cyc + 1));
    chk("t1_rsp_cycle", MW'(rv), MW'(t + 150));
    chk("t1_rsp_valid", MW'(o_rsp_valid), MW'(2'b01));
    chk("t1_rsp_mat", o_rsp_mat, P);
    chk("t1_status", MW'(o_rsp_status), MW'(2'b00));
    consume(0);
    wait_for(3, 5, at);

    // Backpressure: response held 20 cycles, req1 waits behind it.
    @(posedge i_clk); #2;
    i_req0_mat = C; i_req1_mat = D; stub_res = P; stub_delay = 10; i_req_valid = 2'b01;
    wait_for(0, 10, t);
    @(posedge i_clk); #2;
    i_req_valid = 2'b10;
    wait_for(2, 100, rv);
    snap_mat = o_rsp_mat; snap_st = o_rsp_status;
    @(posedge i_clk); #2;
    i_rsp_ready = 2'b10;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      chk("bp_mat_stable", o_rsp_mat, snap_mat);
      chk("bp_status_stable", MW'(o_rsp_status), MW'(snap_st));
      chk("bp_no_ready", MW'(o_req_ready), '0);
      chk("bp_rsp_valid", MW'(o_rsp_valid), MW'(2'b01));
    end
    @(posedge i_clk); #2;
    i_rsp_ready = 2'b01; rc = cyc;
    @(posedge i_clk); #2;
    i_rsp_ready = 2'b00;
    wait_for(1, 10, s);
    chk("bp_next_start", MW'(s), MW'(rc + 2));
    chk("bp_next_operand", o_ldlt_mat, D);
    @(posedge i_clk); #2;
    i_req_valid = 2'b00;
    wait_for(2, 100, rv);
    chk("bp_req1_rsp", MW'(o_rsp_valid), MW'(2'b10));
    consume(1);

    // Zero pivot and divide-by-zero.
    run_job(0, A, Z22, 0, 3, 30, rv);
    chk("pivot22_status", MW'(o_rsp_status), MW'(2'b01));
    chk("pivot22_mat", o_rsp_mat, Z22);
    consume(0);
    run_job(1, B1, P, 1, 3, 30, rv);
    chk("divzero_status", MW'(o_rsp_status), MW'(2'b01));
    consume(1);
    run_job(0, A, Z55, 0, 3, 30, rv);
    chk("pivot55_status", MW'(o_rsp_status), MW'(2'b01));
    consume(0);

    // Done on the final WAIT cycle wins over the timeout.
    run_job(1, C, P, 0, TO, TO + 20, rv);
    chk("edge_done_status", MW'(o_rsp_status), MW'(2'b00));
    chk("edge_done_mat", o_rsp_mat, P);
    chk("edge_done_no_err", MW'(o_timeout_err), '0);
    consume(1);

    // Timeout: engine never finishes.
    run_job(0, D, P, 0, 0, 400, rv);
    chk("to_rsp_cycle", MW'(rv), MW'(start_cyc + 256));
    chk("to_mat", o_rsp_mat, '0);
    chk("to_status", MW'(o_rsp_status), MW'(2'b10));
    chk("to_err", MW'(o_timeout_err), MW'(1'b1));
    consume(0);
    wait_for(3, 5, at);
    late_req++;
    repeat (5) @(negedge i_clk);
    chk("late_done_idle", MW'({o_busy, o_rsp_valid}), '0);
    chk("late_done_err_sticky", MW'(o_timeout_err), MW'(1'b1));

    // Reset in the middle of WAIT.
    @(posedge i_clk); #2;
    stub_delay = 0; i_req1_mat = D; i_req_valid = 2'b10;
    wait_for(0, 10, t);
    @(posedge i_clk); #2;
    i_req_valid = 2'b00;
    wait_for(1, 5, s);
    repeat (50) @(posedge i_clk);
    #2 i_rst = 1'b1;
    i_req_valid = 2'b11; i_req0_mat = A; i_req1_mat = B1;
    #1;
    chk("midrst_outputs", MW'({o_req_ready, o_rsp_valid, o_rsp_status, o_ldlt_start, o_busy, o_timeout_err}), '0);
    chk("midrst_mats", o_ldlt_mat | o_rsp_mat, '0);
    repeat (2) @(posedge i_clk);
    #2 i_rst = 1'b0; stub_delay = 5; stub_res = P;
    @(negedge i_clk);
    chk("midrst_tie_grant", MW'(o_req_ready), MW'(2'b01));
    @(posedge i_clk); #2;
    i_req_valid = 2'b00;
    wait_for(2, 30, rv);
    chk("midrst_rsp_req0", MW'(o_rsp_valid), MW'(2'b01));
    consume(0);
    wait_for(3, 5, at);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
